// File: rtl/fmm_pkg.sv
// Shared types and helpers for the fetch memory model: slot descriptor layout,
// default rates/seed, the xorshift32 hash and the per-slot descriptor generator.
package fmm_pkg;

    localparam int          PC_BITS       = 32;
    localparam int unsigned FMM_BR_RATE   = 20;
    localparam int unsigned FMM_CALL_RATE = 10;
    localparam int unsigned FMM_BACK_RATE = 30;
    localparam logic [31:0] FMM_SEED      = 32'h0000_0001;

    typedef struct packed {
        logic               valid;
        logic               is_branch;
        logic               backward;
        logic               call;
        logic [PC_BITS-1:0] target;
    } fmm_slot_t;

    localparam int SLOT_W = $bits(fmm_slot_t);

    function automatic logic [31:0] fmm_hash(input logic [31:0] idx, input logic [31:0] seed);
        logic [31:0] x;
        x = idx ^ seed;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    // Descriptor for one instruction slot; a pure function of the aligned slot PC.
    function automatic fmm_slot_t fmm_gen_slot(input logic [PC_BITS-1:0] pc,
                                               input int unsigned       entries,
                                               input logic [31:0]       seed,
                                               input int unsigned       br_rate,
                                               input int unsigned       call_rate,
                                               input int unsigned       back_rate);
        fmm_slot_t   s;
        logic [31:0] idx;
        logic [31:0] x;
        logic [31:0] k;
        logic        br;
        logic        bw;
        logic        cl;
        s   = '0;
        idx = 32'(pc >> 2);
        if (idx < entries) begin
            x  = fmm_hash(idx, seed);
            br = ((32'(x[7:0]) % 32'd100) < br_rate);
            cl = ((32'(x[15:8]) % 32'd100) < call_rate) && !br;
            bw = br && ((32'(x[23:16]) % 32'd100) < back_rate) && (idx > 32'd8);
            k  = 32'd4 + (32'(x[26:24]) % 32'd5);
            s.valid     = 1'b1;
            s.is_branch = br;
            s.backward  = bw;
            s.call      = cl;
            if (br) begin
                s.target = bw ? (pc - PC_BITS'(k << 2)) : (pc + PC_BITS'(k << 2));
            end else begin
                s.target = pc + PC_BITS'(4);
            end
        end else begin
            s = '0;
        end
        return s;
    endfunction

endpackage

// File: rtl/fetch_mem_model_if.sv
// Request/response bus between the IF fetch unit (master) and the I-side memory (slave).
interface fetch_mem_model_if import fmm_pkg::*; #(
    parameter int FETCH_W = 2
) ();
    logic                       flush;
    logic                       req_valid;
    logic                       req_ready;
    logic [PC_BITS-1:0]         req_pc;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [PC_BITS-1:0]         rsp_pc;
    logic [FETCH_W*SLOT_W-1:0]  rsp_slot;

    modport master (
        output flush, req_valid, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_pc, rsp_slot
    );

    modport slave (
        input  flush, req_valid, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_pc, rsp_slot
    );
endinterface

// File: rtl/fmm_rsp_fifo.sv
// In-order response FIFO with synchronous flush, occupancy count and full/empty flags.
module fmm_rsp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : (p + PTR_W'(1));
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end
endmodule

// File: rtl/fetch_mem_model.sv
// Parametrised I-side memory model: fixed-latency, in-order, credit-limited fetch responses.
// Build option FMM_STALL_INJECT_EN adds LFSR-driven masking of rsp_valid.
module fetch_mem_model import fmm_pkg::*; #(
    parameter int unsigned FETCH_W      = 2,
    parameter int unsigned IMEM_ENTRIES = 256,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned RSP_DEPTH    = 4,
    parameter int unsigned BR_RATE      = FMM_BR_RATE,
    parameter int unsigned CALL_RATE    = FMM_CALL_RATE,
    parameter int unsigned BACK_RATE    = FMM_BACK_RATE,
    parameter logic [31:0] SEED         = FMM_SEED
) (
    input logic               clk,
    input logic               rst_n,
    fetch_mem_model_if.slave  bus
);
    localparam int DATA_W = PC_BITS + int'(FETCH_W) * SLOT_W;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    logic               ready_en_r;
    logic [CNT_W-1:0]   credit_r;
    logic               accept_s;
    logic               pop_s;
    logic               stall_s;
    logic [PC_BITS-1:0] aligned_pc_s;
    logic [DATA_W-1:0]  gen_data_s;
    logic               push_s;
    logic [DATA_W-1:0]  push_data_s;
    logic [DATA_W-1:0]  head_data_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               unused_s;

    assign bus.req_ready = ready_en_r && !bus.flush &&
                           (credit_r < CNT_W'(RSP_DEPTH)) && !fifo_full_s;
    assign accept_s      = bus.req_valid && bus.req_ready;
    assign pop_s         = bus.rsp_valid && bus.rsp_ready && !bus.flush;
    assign unused_s      = ^fifo_count_s;

    // Build the packed response word {slots, pc} for the presented request PC
    always_comb begin
        aligned_pc_s = {bus.req_pc[PC_BITS-1:2], 2'b00};
        gen_data_s   = '0;
        gen_data_s[PC_BITS-1:0] = aligned_pc_s;
        for (int i = 0; i < int'(FETCH_W); i++) begin
            gen_data_s[PC_BITS + i*SLOT_W +: SLOT_W] =
                fmm_gen_slot(aligned_pc_s + PC_BITS'(4 * i), IMEM_ENTRIES, SEED,
                             BR_RATE, CALL_RATE, BACK_RATE);
        end
    end

    // req_ready is held low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en_r <= 1'b0;
        else        ready_en_r <= 1'b1;
    end

    // Credits cover everything accepted and not yet popped (pipeline + FIFO)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_r <= '0;
        end else if (bus.flush) begin
            credit_r <= '0;
        end else if (accept_s && !pop_s) begin
            credit_r <= credit_r + CNT_W'(1);
        end else if (!accept_s && pop_s) begin
            credit_r <= credit_r - CNT_W'(1);
        end else begin
            credit_r <= credit_r;
        end
    end

    // The last latency cycle is the FIFO write itself, so only LATENCY-1 stages sit in front
    generate
        if (LATENCY <= 1) begin : g_direct
            assign push_s      = accept_s;
            assign push_data_s = gen_data_s;
        end else begin : g_pipe
            logic [LATENCY-2:0] pipe_v_r;
            logic [DATA_W-1:0]  pipe_d_r [LATENCY-1];

            // Valid/data shift pipeline
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_v_r <= '0;
                    for (int j = 0; j < int'(LATENCY) - 1; j++) pipe_d_r[j] <= '0;
                end else if (bus.flush) begin
                    pipe_v_r <= '0;
                end else begin
                    pipe_v_r[0] <= accept_s;
                    pipe_d_r[0] <= gen_data_s;
                    for (int j = 1; j < int'(LATENCY) - 1; j++) begin
                        pipe_v_r[j] <= pipe_v_r[j-1];
                        pipe_d_r[j] <= pipe_d_r[j-1];
                    end
                end
            end

            assign push_s      = pipe_v_r[LATENCY-2] && !bus.flush;
            assign push_data_s = pipe_d_r[LATENCY-2];
        end
    endgenerate

    fmm_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_data_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

`ifdef FMM_STALL_INJECT_EN
    logic [15:0] lfsr_r;

    // x^16+x^14+x^13+x^11+1 Fibonacci LFSR, free-running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_r <= 16'hACE1;
        else        lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end

    assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
    assign stall_s = 1'b0;
`endif

    // Data follows FIFO occupancy, not the mask, so a stalled head stays put
    assign bus.rsp_valid = !fifo_empty_s && !stall_s;
    assign bus.rsp_pc    = fifo_empty_s ? '0 : head_data_s[PC_BITS-1:0];
    assign bus.rsp_slot  = fifo_empty_s ? '0 : head_data_s[DATA_W-1:PC_BITS];
endmodule

// File: tb/tb_fetch_mem_model.sv
// Scoreboard bench for fetch_mem_model: stimulus pushes expected responses, a monitor pops and compares.
module tb_fetch_mem_model;
    import fmm_pkg::*;

    localparam int FW      = 2;
    localparam int LAT     = 2;
    localparam int DEPTH   = 4;
    localparam int ENTRIES = 256;
    localparam int SW      = 36;

    typedef struct {
        logic [31:0]      pc;
        logic [FW*SW-1:0] slots;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    logic            hold_v = 1'b0;
    logic [31:0]     hold_pc;
    logic [FW*SW-1:0] hold_slot;

    fetch_mem_model_if #(.FETCH_W(FW)) bus ();

    fetch_mem_model #(
        .FETCH_W(FW), .IMEM_ENTRIES(ENTRIES), .LATENCY(LAT), .RSP_DEPTH(DEPTH),
        .BR_RATE(20), .CALL_RATE(10), .BACK_RATE(30), .SEED(32'h1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] xs32(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [SW-1:0] m_slot(input logic [31:0] pc);
        logic [31:0] idx, x, tgt;
        logic        br, bw, cl;
        int          k;
        idx = pc >> 2;
        if (idx >= ENTRIES) return '0;
        x   = xs32(idx ^ 32'h1);
        br  = (x[7:0] % 100) < 20;
        cl  = !br && ((x[15:8] % 100) < 10);
        bw  = br && ((x[23:16] % 100) < 30) && (idx > 8);
        k   = 4 + int'(x[26:24] % 5);
        tgt = !br ? pc + 4 : (bw ? pc - 4*k : pc + 4*k);
        return {1'b1, br, bw, cl, tgt};
    endfunction

    function automatic logic [FW*SW-1:0] m_fetch(input logic [31:0] pc);
        logic [31:0] a;
        a = {pc[31:2], 2'b00};
        return {m_slot(a + 32'd4), m_slot(a)};
    endfunction

    // Monitor: pop-and-compare on every accepted response, plus hold and descriptor properties
    always @(negedge clk) begin
        if (rst_n && !bus.flush) begin
            if (hold_v)
                check("hold_stable", {bus.rsp_valid, bus.rsp_pc, bus.rsp_slot}, {1'b1, hold_pc, hold_slot});
            hold_v    = bus.rsp_valid && !bus.rsp_ready;
            hold_pc   = bus.rsp_pc;
            hold_slot = bus.rsp_slot;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=pc_%h required=no_response", bus.rsp_pc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_pc", bus.rsp_pc, mon_e.pc);
                    check("rsp_slot", bus.rsp_slot, mon_e.slots);
                    for (int s = 0; s < FW; s++) begin
                        logic [SW-1:0] sl;
                        logic [31:0]   spc, diff;
                        sl  = bus.rsp_slot[s*SW +: SW];
                        spc = bus.rsp_pc + 32'(4*s);
                        if (sl[34]) begin
                            diff = sl[33] ? spc - sl[31:0] : sl[31:0] - spc;
                            check("target_range", (diff >= 16 && diff <= 32 && diff[1:0] == 2'b00), 1'b1);
                        end
                        if ((spc >> 2) <= 8) check("no_backward_low_idx", sl[33], 1'b0);
                    end
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [FW*SW-1:0] slots,
                         input int budget, output bit acc);
        exp_t e;
        acc = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        for (int c = 0; c < budget && !acc; c++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc     = 1'b1;
                e.pc    = {pc[31:2], 2'b00};
                e.slots = slots;
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [FW*SW-1:0] slots);
        bit acc;
        issue(pc, slots, 20, acc);
        check("accepted", acc, 1'b1);
    endtask

    task automatic fetch_timed(input logic [31:0] pc, input logic [FW*SW-1:0] slots);
        fetch(pc, slots);
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            check("latency_early", bus.rsp_valid, 1'b0);
            step();
        end
        @(negedge clk);
        check("latency_on_time", bus.rsp_valid, 1'b1);
        step();
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && sb_q.size() != 0; c++) step();
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        bit acc;
        int nacc;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_pc    = 32'h0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_rsp_pc", bus.rsp_pc, 32'h0);
        check("rst_rsp_slot", bus.rsp_slot, 72'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_release_cycle", bus.req_ready, 1'b0);
        step();
        @(negedge clk);
        check("ready_after_release", bus.req_ready, 1'b1);
        step();

        // Single fetch of 0x40: hand-derived descriptors for idx 16 and 17
        fetch_timed(32'h40, {36'h9_0000_0048, 36'hC_0000_0050});
        drain(20);

        // Determinism: 0x80 three times interleaved with other PCs
        fetch(32'h80, m_fetch(32'h80));
        fetch(32'h1000, 72'h0);
        fetch(32'h80, m_fetch(32'h80));
        fetch(32'h2C, m_fetch(32'h2C));
        fetch(32'h80, m_fetch(32'h80));
        drain(30);

        // Reset mid-traffic
        bus.rsp_ready = 1'b0;
        fetch(32'h200, m_fetch(32'h200));
        fetch(32'h204, m_fetch(32'h204));
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        check("midrst_req_ready", bus.req_ready, 1'b0);
        sb_q.delete();
        step();
        step();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        step();
        @(negedge clk);
        check("midrst_ready_back", bus.req_ready, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            @(negedge clk);
            check("midrst_no_stale", bus.rsp_valid, 1'b0);
        end
        step();

        // Backpressure / full
        bus.rsp_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] p;
            p = 32'h300 + 32'(8*i);
            issue(p, m_fetch(p), 1, acc);
            nacc += int'(acc);
        end
        check("full_accept_count", nacc, 4);
        @(negedge clk);
        check("full_ready_low", bus.req_ready, 1'b0);
        step();
        bus.rsp_ready = 1'b1;
        drain(40);
        fetch(32'h320, m_fetch(32'h320));
        fetch(32'h328, m_fetch(32'h328));
        drain(20);

        // Flush with three in flight and a request presented in the flush cycle
        bus.rsp_ready = 1'b0;
        fetch(32'h400, m_fetch(32'h400));
        fetch(32'h404, m_fetch(32'h404));
        fetch(32'h408, m_fetch(32'h408));
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h500;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("flush_req_not_ready", bus.req_ready, 1'b0);
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        sb_q.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("flush_no_rsp", bus.rsp_valid, 1'b0);
            step();
        end
        fetch_timed(32'h600, m_fetch(32'h600));
        drain(20);

        // Boundaries: last entry, wrap at top of address space, low-index sweep
        fetch(32'h3FC, {36'h0, m_slot(32'h3FC)});
        fetch(32'hFFFF_FFFC, {36'h8_0000_0004, 36'h0});
        fetch(32'hFFFF_FFFE, {36'h8_0000_0004, 36'h0});
        for (int i = 0; i <= 8; i++) fetch(32'(4*i), m_fetch(32'(4*i)));
        drain(40);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
